// File: rtl/wc_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wc_io_pkg
//  Purpose  : Shared helpers for the WC pad bridge: beat ratio between the
//             core word and the pad bus, counter-width helper and the
//             serialiser state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package wc_io_pkg;

   // Smallest legal number of pin beats per core word.
   localparam int MIN_RATIO = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   // Number of pin beats that make up one core word.
   function automatic int beat_ratio(input int core_w, input int pin_w);
      return core_w / pin_w;
   endfunction

   // Bits needed to index n items; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/wc_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wc_sync_fifo
//  Purpose  : Single-clock word FIFO with registered full/empty flags and
//             show-ahead read data (pop_data is valid whenever !empty).
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             push, push_data - write request / data (ignored when full)
//             pop             - read request (ignored when empty)
//             pop_data        - word at the head of the FIFO
//             full, empty     - registered occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module wc_sync_fifo
   import wc_io_pkg::*;
#(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW    = cnt_width(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // Storage carries no reset: contents are only observable through the
   // flags, which are reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == CNT_W'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule
`default_nettype wire

// File: rtl/wc_pad_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : wc_pad_bridge
//  Purpose  : Pad-side bridge for the WC core. Gathers narrow pin beats into
//             core words (LSB beat first) and serialises core result words
//             back onto narrow pins with valid/last framing.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             pin_d, pin_dv                 - input beats from pads
//             core_in, core_in_valid/ready  - assembled word to core
//             core_out, core_out_valid/ready- result words from core
//             pin_z, pin_zv, pin_zlast      - output beats to pads
//             ovf                           - sticky input-overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module wc_pad_bridge
   import wc_io_pkg::*;
#(
   parameter int PIN_W       = 10,
   parameter int CORE_W      = 40,
   parameter int OFIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PIN_W-1:0]  pin_d,
   input  logic              pin_dv,
   output logic [CORE_W-1:0] core_in,
   output logic              core_in_valid,
   input  logic              core_in_ready,
   input  logic [CORE_W-1:0] core_out,
   input  logic              core_out_valid,
   output logic              core_out_ready,
   output logic [PIN_W-1:0]  pin_z,
   output logic              pin_zv,
   output logic              pin_zlast,
   output logic              ovf
);

   localparam int            R         = beat_ratio(CORE_W, PIN_W);
   localparam int            CW        = cnt_width(R);
   localparam logic [CW-1:0] LAST_BEAT = CW'(R - 1);
   localparam logic [CW-1:0] PRE_LAST  = CW'(R - 2);

   generate
      if ((CORE_W % PIN_W) != 0 || R < MIN_RATIO || OFIFO_DEPTH < 2 ||
          (OFIFO_DEPTH & (OFIFO_DEPTH - 1)) != 0) begin : g_bad_params
         $fatal(1, "wc_pad_bridge: CORE_W must be a multiple of PIN_W (ratio >= 2) and OFIFO_DEPTH a power of two >= 2");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Input assembly
   // ------------------------------------------------------------------
   logic [CORE_W-1:0] asm_q;
   logic [CORE_W-1:0] asm_next;
   logic [CW-1:0]     in_cnt;
   logic              hold_drain;

   // Assembly register with the current beat already merged in, so the
   // completing beat can go straight into the hold register.
   always_comb begin
      asm_next = asm_q;
      asm_next[in_cnt*PIN_W +: PIN_W] = pin_d;
   end

   assign hold_drain = core_in_valid && core_in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         asm_q         <= '0;
         in_cnt        <= '0;
         core_in       <= '0;
         core_in_valid <= 1'b0;
         ovf           <= 1'b0;
      end else begin
         if (hold_drain) core_in_valid <= 1'b0;
         if (pin_dv) begin
            asm_q <= asm_next;
            if (in_cnt == LAST_BEAT) begin
               in_cnt <= '0;
               // A hold register draining this cycle frees room for the
               // new word; otherwise the new word is lost.
               if (!core_in_valid || hold_drain) begin
                  core_in       <= asm_next;
                  core_in_valid <= 1'b1;
               end else begin
                  ovf <= 1'b1;
               end
            end else begin
               in_cnt <= in_cnt + CW'(1);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [CORE_W-1:0] fifo_data;

   // Held low during reset so the core never pushes into a FIFO being cleared.
   assign core_out_ready = !fifo_full && !rst;
   assign fifo_push      = core_out_valid && core_out_ready;

   wc_sync_fifo #(
      .WIDTH (CORE_W),
      .DEPTH (OFIFO_DEPTH)
   ) u_ofifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (core_out),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // ------------------------------------------------------------------
   // Serialiser
   // ------------------------------------------------------------------
   ser_state_t        state;
   logic [CORE_W-1:0] shift_q;
   logic [CW-1:0]     out_cnt;   // index of the beat currently on the pins

   // Pop when idle, or at the end of the last beat so the next word's
   // first beat follows without a bubble.
   assign fifo_pop = !fifo_empty &&
                     ((state == IDLE) || (out_cnt == LAST_BEAT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_q   <= '0;
         out_cnt   <= '0;
         pin_z     <= '0;
         pin_zv    <= 1'b0;
         pin_zlast <= 1'b0;
      end else if (fifo_pop) begin
         state     <= SEND;
         pin_z     <= fifo_data[PIN_W-1:0];
         pin_zv    <= 1'b1;
         pin_zlast <= 1'b0;
         shift_q   <= fifo_data >> PIN_W;
         out_cnt   <= '0;
      end else if (state == SEND) begin
         if (out_cnt == LAST_BEAT) begin
            state     <= IDLE;
            pin_z     <= '0;
            pin_zv    <= 1'b0;
            pin_zlast <= 1'b0;
            out_cnt   <= '0;
         end else begin
            pin_z     <= shift_q[PIN_W-1:0];
            shift_q   <= shift_q >> PIN_W;
            out_cnt   <= out_cnt + CW'(1);
            pin_zlast <= (out_cnt == PRE_LAST);
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/wc_pad_bridge.md
# wc_pad_bridge

Parametrised pad-side bridge for the Winograd convolution chips. It sits between the I/O pad ring and the WC core. On the input side it gathers narrow pin beats into full core words and hands them to the core over a valid/ready handshake. On the output side it buffers core result words in a small FIFO and serialises them back onto the narrow output pins with a valid/last framing strobe. This allows a wider core datapath (for example a 40-bit tile word) behind the existing 10-pin pad budget.

## Interface
- PIN_W, 10, width of pad data buses (D and Z pins)
- CORE_W, 40, core word width; must be an integer multiple of PIN_W (R = CORE_W/PIN_W, R ≥ 2)
- OFIFO_DEPTH, 4, output word FIFO depth; power of two, ≥ 2

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- pin_d  in  PIN_W  input beat from pads
- pin_dv  in  1  input beat valid (no pin-side backpressure)
- core_in  out  CORE_W  assembled word to core
- core_in_valid  out  1  core_in holds a complete word
- core_in_ready  in  1  core accepts word
- core_out  in  CORE_W  result word from core
- core_out_valid  in  1  result word present
- core_out_ready  out  1  FIFO can accept (= not full)
- pin_z  out  PIN_W  output beat to pads
- pin_zv  out  1  output beat valid
- pin_zlast  out  1  final beat of a word
- ovf  out  1  sticky input-overflow flag

## Operation
- Input assembly:
  - The beat counter runs 0..R-1. Beat k is written to the assembly register bits [k*PIN_W +: PIN_W], LSB first.
  - When beat R-1 is accepted, the assembly register is copied into the hold register, core_in_valid is set, and the counter wraps to 0.
  - Assembly of the next word continues while the hold register is occupied.
  - The hold register clears on core_in_valid && core_in_ready.
  - If beat R-1 completes while the hold register is still occupied and not being drained in the same cycle:
    - the new word is dropped;
    - ovf is set and stays set until rst;
    - the counter still wraps.
  - If the hold register drains in the same cycle that a new word completes, the new word is loaded (no overflow).
- Output FIFO: a word is pushed on core_out_valid && core_out_ready. core_out_ready = !full, based on the registered count. Push and pop may happen in the same cycle.
- Serialiser FSM:
  - IDLE: if the FIFO is not empty, pop one word into the shift register and go to SEND.
  - SEND: drive pin_z = shift[PIN_W-1:0] with pin_zv = 1, shift right by PIN_W each cycle, and count beats.
  - On beat R-1, pin_zlast = 1. If the FIFO is not empty, pop the next word in the same cycle and stay in SEND (no bubble). Otherwise go to IDLE.
- Arithmetic: no arithmetic on data; bit positions only. Counters are $clog2(R) bits wide; the FIFO count is $clog2(OFIFO_DEPTH)+1 bits wide.

## Timing
- Reset values: core_in = 0, core_in_valid = 0, core_out_ready = 0 during rst (then 1 on the first cycle after), pin_z = 0, pin_zv = 0, pin_zlast = 0, ovf = 0. FSM = IDLE, counters = 0, FIFO empty.
- Input latency: beat R-1 sampled at edge t → core_in_valid high after edge t (visible in cycle t+1).
- Output latency: push at edge t into an empty FIFO with the FSM IDLE → pop at edge t+1 → first pin_zv beat visible after edge t+1. Minimum word latency is 2 cycles to the first beat and R+1 cycles to pin_zlast.
- Throughput: one pin beat per cycle sustained both directions; back-to-back output words have zero gap.
- Reset mid-operation: a partially assembled input word, the held word, FIFO contents and any in-flight serial word are discarded. No partial frame is emitted after rst deasserts.
- pin_zv is low whenever no word is being sent; pin_z is held at 0 when pin_zv is low.

## Structure
- Package wc_io_pkg: function/localparam for R = CORE_W/PIN_W, counter-width helper, serialiser state enum (IDLE, SEND).
- Elaboration check: CORE_W % PIN_W == 0 and OFIFO_DEPTH a power of two; otherwise fatal.
- Sub-module wc_sync_fifo (CORE_W wide, OFIFO_DEPTH deep, registered full/empty, same-cycle push/pop). The assembler and serialiser stay in the top module.

## Test plan
- Input assembly: PIN_W = 10, CORE_W = 40, drive beats 0x001, 0x002, 0x003, 0x004 with core_in_ready = 1 → core_in = 0x004_003_002_001 (packed LSB first), valid for one cycle, ovf = 0.
- Input overflow: core_in_ready = 0 and 8 consecutive beats → first word held, second word dropped, ovf = 1. After core_in_ready = 1, exactly one word is delivered and ovf stays 1.
- Output serialisation: push 0x3FF_155_2AA_000, then push a second word immediately → pin_z sequence 0x000, 0x2AA, 0x155, 0x3FF, then the next word's beats with no gap. pin_zlast is high on beats 4 and 8.
- FIFO full: hold pushes until 4 words are queued while the serialiser is busy → core_out_ready drops to 0 at count 4 and returns to 1 the cycle after the next pop. No word is lost or duplicated.
- Reset mid-frame: assert rst during beat 2 of an output word and after 2 input beats → all outputs return to their reset values. The next 4 input beats form a clean word, and no stale pin_zv appears.
- Parameter sweep: PIN_W = 8, CORE_W = 16, OFIFO_DEPTH = 2 with random traffic on both sides → scoreboard matches; ovf = 0 whenever core_in_ready keeps up.
